// File: rtl/st_if.sv
// Store unit bus: controller request fields, RAM port and status.
interface st_if;
  logic        start;
  logic [15:0] ins;
  logic [15:0] A_in;
  logic [15:0] B_in;
  logic [15:0] ram_rdata;
  logic [7:0]  address;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic        ram_re;
  logic        busy;
  logic        done;

  modport master (
    output start, ins, A_in, B_in, ram_rdata,
    input  address, ram_wdata, ram_we, ram_re,
    input  busy, done
  );

  modport slave (
    input  start, ins, A_in, B_in, ram_rdata,
    output address, ram_wdata, ram_we, ram_re,
    output busy, done
  );
endinterface

// File: rtl/st_unit.sv
// Store unit for the Green 16-bit datapath (word and byte stores to RAM).
// ST_BYTE_EN builds the read-modify-write path for byte stores.
module st_unit (
  input  logic clk,
  input  logic reset_n,
  st_if.slave  bus
);

`ifdef ST_BYTE_EN
  typedef enum logic [1:0] {
    IDLE, WRITE, READ, MERGE
  } state_t;
`else
  typedef enum logic [0:0] {
    IDLE, WRITE
  } state_t;
`endif

  state_t      state, nxt;
  logic [7:0]  addr;
  logic [15:0] src;
  logic [15:0] sel;
  logic [15:0] wdata;
  logic        we, re;

  assign sel = bus.ins[11] ? bus.B_in : bus.A_in;

`ifdef ST_BYTE_EN
  logic lane;
  logic unused_ok;
  assign unused_ok = ^{bus.ins[15:12], bus.ins[8]};
`else
  logic unused_ok;
  assign unused_ok = ^{bus.ins[15:12], bus.ins[9:8],
                       bus.ram_rdata};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      addr  <= '0;
      src   <= '0;
`ifdef ST_BYTE_EN
      lane  <= 1'b0;
`endif
    end else begin
      state <= nxt;
      if (state == IDLE && bus.start) begin
        addr <= bus.ins[7:0];
`ifdef ST_BYTE_EN
        src  <= sel;
        lane <= bus.ins[9];
`else
        // Without byte support a byte store writes a zero-extended byte
        src  <= bus.ins[10] ? {8'h00, sel[7:0]} : sel;
`endif
      end
    end
  end

  always_comb begin
    nxt   = state;
    we    = 1'b0;
    re    = 1'b0;
    wdata = '0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
`ifdef ST_BYTE_EN
          nxt = bus.ins[10] ? READ : WRITE;
`else
          nxt = WRITE;
`endif
        end
      end
      WRITE: begin
        we    = 1'b1;
        wdata = src;
        nxt   = IDLE;
      end
`ifdef ST_BYTE_EN
      READ: begin
        re  = 1'b1;
        nxt = MERGE;
      end
      MERGE: begin
        we    = 1'b1;
        wdata = lane ? {src[7:0], bus.ram_rdata[7:0]}
                     : {bus.ram_rdata[15:8], src[7:0]};
        nxt   = IDLE;
      end
`endif
      default: nxt = IDLE;
    endcase
  end

  assign bus.address   = addr;
  assign bus.ram_wdata = wdata;
  assign bus.ram_we    = we;
  assign bus.ram_re    = re;
  assign bus.done      = we;
  assign bus.busy      = (state != IDLE);

endmodule
